// File: rtl/byte_mem_port.sv
// byte_mem_port: MEM-stage responder that services big-endian byte/word
// loads and stores against a word-only synchronous SRAM.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_we, req_size    1 = store / 1 = word access
//   req_signed          sign-extend byte loads
//   req_addr, req_wdata byte address and store data (byte stores use [7:0])
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  load result / misaligned-word error, valid with rsp_valid
//   mem_en, mem_we      SRAM strobe and write qualifier
//   mem_addr, mem_wdata SRAM word address and write data (held between strobes)
//   mem_rdata           SRAM read data, valid the cycle after a read strobe
//
// Byte stores are read-modify-write because the SRAM has no byte enables.
// Every output is a register, so nothing combinational reaches the pins
// from req_* or mem_rdata.
module byte_mem_port #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic              size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [7:0]        wbyte_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic [7:0]        lane_byte;
  logic [31:0]       load_word;
  logic [31:0]       merged_word;
  logic              unused_addr_bits;

  // Upper address bits beyond the SRAM word range are deliberately ignored.
  assign unused_addr_bits = ^req_addr;

  // Big-endian lane select: lane 0 is the most significant byte.
  always_comb begin
    lane_byte   = mem_rdata[7:0];
    merged_word = mem_rdata;
    unique case (lane_q)
      2'd0: begin
        lane_byte          = mem_rdata[31:24];
        merged_word[31:24] = wbyte_q;
      end
      2'd1: begin
        lane_byte          = mem_rdata[23:16];
        merged_word[23:16] = wbyte_q;
      end
      2'd2: begin
        lane_byte         = mem_rdata[15:8];
        merged_word[15:8] = wbyte_q;
      end
      default: begin
        lane_byte        = mem_rdata[7:0];
        merged_word[7:0] = wbyte_q;
      end
    endcase
    if (size_q) begin
      load_word = mem_rdata;
    end else begin
      load_word = {{24{signed_q & lane_byte[7]}}, lane_byte};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      signed_q    <= 1'b0;
      lane_q      <= '0;
      wbyte_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            size_q      <= req_size;
            signed_q    <= req_signed;
            lane_q      <= req_addr[1:0];
            wbyte_q     <= req_wdata[7:0];
            req_ready_q <= 1'b0;
            if (req_size && (req_addr[1:0] != 2'b00)) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              // Strobe is registered here so it is live throughout ISSUE.
              state_q    <= S_ISSUE;
              mem_en_q   <= 1'b1;
              mem_we_q   <= req_we & req_size;
              mem_addr_q <= req_addr[MEM_AW+1:2];
              if (req_we && req_size) begin
                mem_wdata_q <= req_wdata;
              end
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (we_q && size_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (we_q) begin
            // mem_wdata_q doubles as the merged-word holding register.
            state_q     <= S_WRITE;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merged_word;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_word;
          end
        end
        S_WRITE: begin
          state_q     <= S_RESP;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/byte_mem_port.md
# byte_mem_port

Memory-side responder for the data-memory stage: accepts big-endian byte/word load and store requests from the pipeline and services them against a word-only synchronous SRAM. Byte loads extract and zero/sign-extend the addressed lane. Byte stores run a read-modify-write (read word, merge byte, write word), since the SRAM has no byte enables. Sits between the MEM stage and the data SRAM and stalls the pipeline via `req_ready`.

## Interface
- `ADDR_W`, default 32: request byte-address width; must be ≥ `MEM_AW`+2.
- `MEM_AW`, default 10: SRAM word-address width.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request (IDLE only).
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  1: 0 = byte, 1 = word.
- `req_signed`  in  1: byte loads only. 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  `ADDR_W`: byte address.
- `req_wdata`  in  32: store data. Byte stores use [7:0].
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  32: load result, valid with `rsp_valid`. 0 for stores and errors.
- `rsp_err`  out  1: misaligned word access, valid with `rsp_valid`.
- `mem_en`  out  1: SRAM access strobe.
- `mem_we`  out  1: SRAM write (qualified by `mem_en`).
- `mem_addr`  out  `MEM_AW`: SRAM word address = `req_addr[MEM_AW+1:2]`. Upper address bits are ignored.
- `mem_wdata`  out  32: SRAM write data.
- `mem_rdata`  in  32: SRAM read data, valid the cycle after a read strobe.

## Operation
- Big-endian lanes: `addr[1:0]` 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0].
- Handshake: a request is accepted on a rising edge with `req_valid && req_ready`. At acceptance, latch `req_we`, `req_size`, `req_signed`, `req_addr`, `req_wdata`. Inputs are ignored at all other times.
- FSM states: IDLE, ISSUE, CAPTURE, WRITE, RESP.
  - IDLE: `req_ready`=1.
    - On acceptance of a word access with `addr[1:0]`≠0: go to RESP with err=1.
    - On any other acceptance: go to ISSUE.
  - ISSUE: `mem_en`=1.
    - Word store: `mem_we`=1, `mem_wdata`=latched wdata, then go to RESP.
    - Loads and byte stores: `mem_we`=0 (read), then go to CAPTURE.
  - CAPTURE: sample `mem_rdata`.
    - Word load: result = word, then go to RESP.
    - Byte load: result = addressed byte, extended per `req_signed`, then go to RESP.
    - Byte store: merged word = `mem_rdata` with the addressed lane replaced by wdata[7:0], held in a register, then go to WRITE.
  - WRITE: `mem_en`=1, `mem_we`=1, `mem_wdata`=merged word, then go to RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle with `rsp_rdata`/`rsp_err`, then go to IDLE. There is no response backpressure.
- `req_ready`=0 in every state except IDLE. At most one transaction is outstanding.
- Misaligned word access: no SRAM strobe, `rsp_rdata`=0, `rsp_err`=1.
- Outside ISSUE/WRITE: `mem_en`=`mem_we`=0. `mem_addr`/`mem_wdata` hold their last values.

## Timing
- Reset values (immediate on `rst_n` low):
  - state = IDLE.
  - `rsp_valid`, `rsp_err`, `mem_en`, `mem_we` = 0.
  - `rsp_rdata`, `mem_addr`, `mem_wdata` = 0.
  - `req_ready` = 0 while `rst_n` is low, 1 in the first cycle after release.
- Latency, with acceptance edge = cycle T and `rsp_valid` high during cycle:
  - Misaligned word access: T+1.
  - Word store: T+2 (SRAM write strobe in T+1).
  - Loads: T+3.
  - Byte store: T+4 (SRAM write strobe in T+3).
- Next acceptance: possible at the earliest in the cycle after RESP.
- All outputs are registered or decoded from state only. There are no combinational paths from `req_*` or `mem_rdata` to outputs.
- Reset mid-transaction: the transaction is dropped with no response.
  - If reset hits during WRITE, the strobe drops asynchronously and the SRAM word is left unmodified. The word is never partially written.
- `req_valid` held high through a transaction does not cause a second acceptance until IDLE.

## Test plan
- **Byte load, zero-extended:** SRAM word 4 = 0x11223344; LBU addr 0x11 -> `rsp_rdata`=0x00000022 at T+3, `rsp_err`=0.
- **Byte load, sign-extended:** word 4 = 0x8899AABB.
  - LB addr 0x12 -> 0xFFFFFFAA.
  - LBU addr 0x12 -> 0x000000AA.
  - LB addr 0x13 -> 0xFFFFFFBB.
- **Byte store RMW:** word 4 = 0x11223344; SB addr 0x12 data 0x5A -> read strobe at T+1, write strobe at T+3 with `mem_wdata`=0x11225A44, `rsp_valid` at T+4. Repeat for lanes 0/1/3 -> 0x5A223344, 0x115A3344, 0x1122335A.
- **Word store/load and misalignment:**
  - SW addr 0x10 data 0xDEADBEEF -> write at T+1, rsp at T+2.
  - LW addr 0x10 -> 0xDEADBEEF at T+3.
  - LW addr 0x12 -> `rsp_err`=1, `rsp_rdata`=0 at T+1, `mem_en` never asserted.
- **Handshake:** `req_valid` held high for 10 cycles with the same byte-store request -> `req_ready` low from T+1 through RESP. Second acceptance occurs in the cycle after RESP. Exactly one `rsp_valid` pulse per acceptance.
- **Reset during WRITE:** SB in progress, `rst_n` low in cycle T+3 -> `mem_en` drops immediately, word 4 unchanged, no `rsp_valid`. After release, `req_ready`=1 and the next LW returns the original word.
